// File: rtl/mult4u_pkg.sv
// Shared widths and FSM encoding for the 4-bit multiplier check/accumulate
// slice.
package mult4u_pkg;

  localparam int NIBBLE_W = 4;
  localparam int PROD_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/mult4u_shift_add_ref.sv
// Four-step shift-add reference multiplier.
// It recomputes a*b one bit of b per cycle.
module mult4u_shift_add_ref
  import mult4u_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  output logic [PROD_W-1:0]   ref_o,
  output logic                fin_o
);

  logic [PROD_W-1:0] ref_q, ref_d;
  logic [1:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [PROD_W-1:0] a_ext;

  assign a_ext = {{(PROD_W-NIBBLE_W){1'b0}}, a_i};

  always_comb begin
    ref_d  = ref_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (start_i) begin
      ref_d  = '0;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_i[idx_q])
        ref_d = ref_q + (a_ext << idx_q);
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3)
        busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  // fin marks the cycle whose edge applies the last bit
  assign ref_o = ref_q;
  assign fin_o = busy_q & (idx_q == 2'd3);

endmodule

// File: rtl/mult4u_check_acc.sv
// Checks incoming 4x4 products against a shift-add reference, corrects them,
// and accumulates the verified result into a saturating accumulator.
module mult4u_check_acc
  import mult4u_pkg::*;
#(
  parameter int ACC_W    = 12,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic [PROD_W-1:0]   p,
  input  logic                clr,
  input  logic                err_clr,
  output logic [ACC_W-1:0]    acc,
  output logic                done,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                ovf
);

  state_e state_q, state_d;

  logic [NIBBLE_W-1:0] a_q, a_d;
  logic [NIBBLE_W-1:0] b_q, b_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                rdy_q, rdy_d;

  logic                accept;
  logic                fin;
  logic                mismatch;
  logic [PROD_W-1:0]   ref_p;
  logic [ACC_W-1:0]    acc_base;
  logic [ERRCNT_W-1:0] cnt_base;
  logic [ACC_W:0]      sum;

  assign accept = in_valid & (state_q == IDLE);

  mult4u_shift_add_ref u_ref (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .a_i     (a_q),
    .b_i     (b_q),
    .ref_o   (ref_p),
    .fin_o   (fin)
  );

  assign mismatch = (ref_p != p_q);
  assign acc_base = clr ? '0 : acc_q;
  assign cnt_base = err_clr ? '0 : cnt_q;
  assign sum = {1'b0, acc_base}
             + {{(ACC_W+1-PROD_W){1'b0}}, ref_p};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    acc_d   = acc_base;
    ovf_d   = clr ? 1'b0 : ovf_q;
    err_d   = err_clr ? 1'b0 : err_q;
    cnt_d   = cnt_base;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          p_d     = p;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (fin)
          state_d = COMMIT;
      end
      COMMIT: begin
        // the reference value is always the one accumulated
        if (sum[ACC_W]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        if (mismatch) begin
          err_d = 1'b1;
          if (!(&cnt_base))
            cnt_d = cnt_base + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign acc      = acc_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_cnt  = cnt_q;
  assign ovf      = ovf_q;

endmodule
